hs_fifo: RTL and testbench
==========================

HS_FIFO -- requirements
Module: hs_fifo

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the payload width in bits.
REQ-003 Parameter DEPTH, default 4, SHALL set the number of entries; legal values are powers of two from 2 to 16.
REQ-004 Port i_clk, input, 1 bit, SHALL be the sole clock; all state updates on its rising edge.
REQ-005 Port i_rst, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-006 Port i_valid, input, 1 bit, SHALL be the upstream write request, driven by a master o_valid.
REQ-007 Port o_ready, output, 1 bit, SHALL be the upstream accept indication, returned to the master i_ready.
REQ-008 Port i_data, input, DATA_W bits, SHALL be the upstream payload.
REQ-009 Port o_valid, output, 1 bit, SHALL be the downstream request, driving a slave i_valid.
REQ-010 Port i_ready, input, 1 bit, SHALL be the downstream accept indication, from a slave o_ready.
REQ-011 Port o_data, output, DATA_W bits, SHALL be the downstream payload.
REQ-012 Port o_level, output, $clog2(DEPTH)+1 bits, SHALL give the current occupancy, 0..DEPTH.

Function
REQ-013 A push SHALL occur in a cycle where i_valid and o_ready are both 1; a pop SHALL occur in a cycle where o_valid and i_ready are both 1.
REQ-014 o_ready SHALL equal (o_level != DEPTH), registered, with no combinational path from i_ready.
REQ-015 o_valid SHALL equal (o_level != 0), registered, with no combinational path from i_valid.
REQ-016 o_data SHALL present the oldest stored entry whenever o_valid=1 (first-word fall-through).
REQ-017 Latency SHALL be 1 cycle: data pushed in cycle N is visible on o_valid/o_data in cycle N+1 at the earliest; there is no combinational bypass.
REQ-018 Once o_valid=1, o_data SHALL stay stable until the pop occurs.
REQ-019 Entries SHALL be delivered in push order, with no loss and no duplication.
REQ-020 Write and read pointers SHALL each be $clog2(DEPTH) bits and wrap modulo DEPTH with no skipped entries.
REQ-021 Level update per cycle: push only gives +1; pop only gives -1; push and pop together give no change.
REQ-022 At level 0, a push SHALL give level 1 and o_valid=1 next cycle; no pop is possible that cycle.
REQ-023 At level DEPTH, o_ready=0, so no push is possible; a pop SHALL give level DEPTH-1 and o_ready=1 next cycle.
REQ-024 At level DEPTH-1, a simultaneous push and pop SHALL keep the level and leave o_ready=1.
REQ-025 Upstream data offered while o_ready=0 SHALL NOT be stored; the upstream holds it per the handshake.
REQ-026 i_data SHALL be ignored when no push occurs; the stored array SHALL be unaffected.

Reset
REQ-027 While i_rst=1, the outputs SHALL be o_valid=0, o_ready=0, o_level=0, with pointers at 0, asynchronously.
REQ-028 o_data SHALL be 0 during reset; array contents need not be reset.
REQ-029 On the first rising edge after i_rst deasserts, o_ready SHALL register to 1 (FIFO empty), with no pushes accepted during that edge.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries immediately; no partial pop is seen downstream.

Structure
REQ-031 A shared package hs_pkg SHALL hold the DATA_W default (32), the DEPTH default (4), and the level-width function.
REQ-032 Storage SHALL be a separate sub-module hs_fifo_mem: DEPTH x DATA_W, one synchronous write port, one asynchronous read port, no reset.
REQ-033 hs_fifo SHALL contain the pointers, level counter, registered flags and handshake logic; the total implementation SHALL be 120-400 lines.

Verification
REQ-034 Reset release, then push 0xA5A5_0001: o_valid=0 in the push cycle, 1 next cycle, o_data=0xA5A5_0001, o_level=1.
REQ-035 Hold i_ready=0 and push 5 words 0x1..0x5 with DEPTH=4: four are accepted, o_ready=0 at level 4, word 0x5 is held upstream; release i_ready: output order is 1,2,3,4,5.
REQ-036 Stream 1000 random words with random i_valid and i_ready (50% each): scoreboard matches in order, o_level never exceeds 4, o_data stable while o_valid=1 and i_ready=0.
REQ-037 At level 4, assert i_ready: the pop completes, o_ready=1 next cycle, and a push in that same pop cycle is rejected.
REQ-038 At level 3 with simultaneous push and pop every cycle for 20 cycles: o_level stays 3, pointers wrap without error, data order is preserved.
REQ-039 Assert i_rst asynchronously mid-stream at level 2: o_valid=0, o_ready=0, o_level=0 immediately; after release, the first popped word is the first one pushed after reset.

Source files
------------

// File: rtl/hs_pkg.sv
// hs_pkg: shared defaults and level-width helper for hs_fifo
package hs_pkg;
  localparam int HS_DATA_W = 32;
  localparam int HS_DEPTH  = 4;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/hs_fifo_mem.sv
// hs_fifo_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read, no reset
module hs_fifo_mem
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = HS_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/hs_fifo.sv
// hs_fifo: first-word fall-through valid/ready FIFO with registered flags
module hs_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = HS_DEPTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_W-1:0]         i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic [lvl_w(DEPTH)-1:0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              rdy_q, rdy_d, vld_q, vld_d, push, pop;
  logic [DATA_W-1:0] rdata;
  // flags come from the next level so they never depend combinationally on i_valid/i_ready
  always_comb begin
    push  = i_valid & rdy_q;
    pop   = vld_q & i_ready;
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    lvl_d = lvl_q + LW'(push) - LW'(pop);
    rdy_d = lvl_d != LW'(DEPTH);
    vld_d = lvl_d != '0;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
      rdy_q <= rdy_d;
      vld_q <= vld_d;
    end
  end
  hs_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (i_clk),
    .we_i    (push),
    .waddr_i (wp_q),
    .wdata_i (i_data),
    .raddr_i (rp_q),
    .rdata_o (rdata)
  );
  assign o_ready = rdy_q;
  assign o_valid = vld_q;
  assign o_level = lvl_q;
  assign o_data  = vld_q ? rdata : '0;
endmodule

// File: tb/tb_hs_fifo.sv
// tb_hs_fifo: directed and random checks of hs_fifo against a queue reference model
module tb_hs_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic          i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
  logic [DW-1:0] i_data = '0, o_data;
  logic          o_ready, o_valid;
  logic [2:0]    o_level;
  int            errs = 0, checks = 0, w;
  bit            fresh = 1'b1, acc = 1'b0;
  logic [DW-1:0] q[$], got[$];

  hs_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ready is high whenever not full, except on the first edge after reset release
  function automatic bit m_rdy();
    return !fresh && q.size() != DEPTH;
  endfunction

  task automatic chk_all();
    chk("level", 64'(o_level), 64'(q.size()));
    chk("level_bound", 64'(o_level <= 3'(DEPTH)), 64'd1);
    chk("valid", 64'(o_valid), 64'(q.size() != 0));
    chk("ready", 64'(o_ready), 64'(m_rdy()));
    chk("data", 64'(o_data), q.size() != 0 ? 64'(q[0]) : 64'd0);
  endtask

  task automatic cyc();
    bit push, pop;
    logic [DW-1:0] d;
    push = i_valid && m_rdy();
    pop  = i_ready && q.size() != 0;
    d = i_data;
    if (pop) got.push_back(o_data);
    @(posedge i_clk);
    if (pop) q.delete(0);
    if (push) q.push_back(d);
    fresh = 1'b0;
    acc = push;
    #1;
    chk_all();
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (DEPTH + 1) cyc();
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    i_rst = 1'b0;
    fresh = 1'b1;
    cyc();
    // first push after reset
    i_valid = 1'b1;
    i_data = 32'hA5A5_0001;
    chk("push_cycle_valid", 64'(o_valid), 64'd0);
    cyc();
    chk("first_data", 64'(o_data), 64'hA5A5_0001);
    chk("first_level", 64'(o_level), 64'd1);
    chk("first_valid", 64'(o_valid), 64'd1);
    drain();
    // fill past full with downstream stalled
    w = 1;
    i_data = 32'd1;
    i_valid = 1'b1;
    i_ready = 1'b0;
    repeat (6) begin
      cyc();
      if (acc && w < 5) begin w++; i_data = w; end
    end
    chk("full_level", 64'(o_level), 64'd4);
    chk("full_ready", 64'(o_ready), 64'd0);
    chk("held_word", 64'(i_data), 64'd5);
    got.delete();
    i_ready = 1'b1;
    cyc();
    chk("pop_at_full_level", 64'(o_level), 64'd3);
    chk("pop_at_full_ready", 64'(o_ready), 64'd1);
    chk("push_rejected", 64'(acc), 64'd0);
    repeat (8) begin
      cyc();
      if (acc) i_valid = 1'b0;
    end
    chk("order_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("order", 64'(got[i]), 64'(i + 1));
    // steady state at DEPTH-1 with push and pop every cycle
    drain();
    i_ready = 1'b0;
    i_valid = 1'b1;
    repeat (3) begin i_data = $urandom; cyc(); end
    chk("lvl3", 64'(o_level), 64'd3);
    i_ready = 1'b1;
    repeat (20) begin
      i_data = $urandom;
      cyc();
      chk("lvl3_hold", 64'(o_level), 64'd3);
      chk("lvl3_ready", 64'(o_ready), 64'd1);
    end
    // random stream; upstream holds a rejected word until it is taken
    drain();
    acc = 1'b0;
    repeat (1000) begin
      if (!(i_valid && !acc)) begin
        i_valid = 1'($urandom_range(0, 1));
        i_data = $urandom;
      end
      i_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    // asynchronous reset at level 2
    drain();
    i_ready = 1'b0;
    i_valid = 1'b1;
    repeat (2) begin i_data = $urandom; cyc(); end
    i_valid = 1'b0;
    chk("pre_rst_level", 64'(o_level), 64'd2);
    #3 i_rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_ready", 64'(o_ready), 64'd0);
    chk("arst_level", 64'(o_level), 64'd0);
    chk("arst_data", 64'(o_data), 64'd0);
    q.delete();
    fresh = 1'b1;
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    i_valid = 1'b1;
    i_data = 32'h77;
    cyc();
    chk("release_edge_no_push", 64'(o_level), 64'd0);
    cyc();
    i_data = 32'h78;
    cyc();
    got.delete();
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) cyc();
    chk("post_rst_count", 64'(got.size()), 64'd2);
    if (got.size() > 0) chk("post_rst_first", 64'(got[0]), 64'h77);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
